// File: rtl/floppy_pkg.sv
// rtl/floppy_pkg.sv - shared states, address marks and CCITT CRC helper for floppy_stream
package floppy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } st_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   localparam logic [7:0] AM_A1 = 8'hA1;
   localparam logic [7:0] AM_FE = 8'hFE;
   localparam logic [7:0] AM_FB = 8'hFB;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   // CRC state after the three sync bytes and the address mark, so fields start from a constant
   localparam logic [15:0] CRC_SEED_ID =
      crc16_byte(crc16_byte(crc16_byte(crc16_byte(CRC_INIT, AM_A1), AM_A1), AM_A1), AM_FE);
   localparam logic [15:0] CRC_SEED_DATA =
      crc16_byte(crc16_byte(crc16_byte(crc16_byte(CRC_INIT, AM_A1), AM_A1), AM_A1), AM_FB);

endpackage

// File: rtl/floppy_sector_buf.sv
// rtl/floppy_sector_buf.sv - 1024x8 simple dual-port sector RAM, registered read (read-old-data)
module floppy_sector_buf #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          wr,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    q
);

   logic [7:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr) mem[waddr] <= wdata;
      q <= mem[raddr];
   end

endmodule

// File: rtl/floppy_stream.sv
// rtl/floppy_stream.sv - ID/data byte stream generator for the FDC front end; optional data CRC under FLOPPY_STREAM_DCRC_EN
module floppy_stream
   import floppy_pkg::*;
#(
   parameter int SECTOR_LEN = 1024,
   parameter int SIZE_CODE  = 3,
   parameter int HDR_LEN    = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dclk_en,
   input  logic [6:0]  track,
   input  logic [3:0]  sector,
   input  logic        sector_hdr,
   input  logic        sector_data,
   input  logic        ready,
   input  logic        side,
   input  logic        buf_wr,
   input  logic [9:0]  buf_addr,
   input  logic [7:0]  buf_din,
   input  logic        buf_done,
   output logic        req,
   output logic [6:0]  req_track,
   output logic        req_side,
   output logic [3:0]  req_sector,
   output logic [7:0]  dout,
   output logic        dout_stb,
   output logic        dout_hdr,
   output logic        data_miss
`ifdef FLOPPY_STREAM_DCRC_EN
   ,
   output logic [15:0] data_crc,
   output logic        data_crc_stb
`endif
);

   localparam int CW = $clog2(SECTOR_LEN);

   st_t           state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          over, over_nxt;
   logic          stb_nxt, entry_hdr, entry_data;
   logic [11:0]   cur_tag, tag, tag_eff;
   logic          tag_valid, tag_valid_eff, tag_hit;
   logic          stb_q, hdr_q, data_ok;
   logic [7:0]    hdr_byte, ram_q;
   logic [15:0]   crc;

   assign cur_tag       = {track, side, sector};
   // A coincident buf_done is applied before any tag comparison
   assign tag_eff       = buf_done ? {req_track, req_side, req_sector} : tag;
   assign tag_valid_eff = buf_done | tag_valid;
   assign tag_hit       = tag_valid_eff && (tag_eff == cur_tag);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      over_nxt  = over;
      stb_nxt   = 1'b0;
      if (dclk_en) begin
         if (!ready) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            over_nxt  = 1'b0;
         end else begin
            if (sector_hdr)       state_nxt = ST_HDR;
            else if (sector_data) state_nxt = ST_DATA;
            else                  state_nxt = ST_IDLE;
            if (state_nxt != state) begin
               cnt_nxt  = '0;
               over_nxt = 1'b0;
            end else if (cnt == CW'(SECTOR_LEN - 1)) begin
               cnt_nxt  = '0;
               over_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
            stb_nxt = !over_nxt && ((state_nxt == ST_DATA) ||
                                    (state_nxt == ST_HDR && cnt_nxt < CW'(HDR_LEN)));
         end
      end
   end

   assign entry_hdr  = (state_nxt == ST_HDR)  && (state != ST_HDR);
   assign entry_data = (state_nxt == ST_DATA) && (state != ST_DATA);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         over  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         over  <= over_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stb_q      <= 1'b0;
         hdr_q      <= 1'b0;
         data_ok    <= 1'b0;
         hdr_byte   <= 8'h00;
         crc        <= CRC_INIT;
         tag        <= '0;
         tag_valid  <= 1'b0;
         req        <= 1'b0;
         req_track  <= '0;
         req_side   <= 1'b0;
         req_sector <= '0;
         data_miss  <= 1'b0;
      end else begin
         stb_q <= stb_nxt;
         hdr_q <= stb_nxt && (state_nxt == ST_HDR);
         if (buf_done) begin
            tag       <= {req_track, req_side, req_sector};
            tag_valid <= 1'b1;
            req       <= 1'b0;
         end
         if (entry_hdr && !tag_hit) begin
            {req_track, req_side, req_sector} <= cur_tag;
            req       <= 1'b1;
            tag_valid <= 1'b0;
         end
         if (dclk_en) data_ok <= tag_hit;
         if (stb_nxt && state_nxt == ST_HDR) begin
            case (cnt_nxt[2:0])
               3'd0: begin
                  hdr_byte <= {1'b0, track};
                  crc      <= crc16_byte(CRC_SEED_ID, {1'b0, track});
               end
               3'd1: begin
                  hdr_byte <= {7'd0, side};
                  crc      <= crc16_byte(crc, {7'd0, side});
               end
               3'd2: begin
                  hdr_byte <= {4'd0, sector};
                  crc      <= crc16_byte(crc, {4'd0, sector});
               end
               3'd3: begin
                  hdr_byte <= 8'(SIZE_CODE);
                  crc      <= crc16_byte(crc, 8'(SIZE_CODE));
               end
               3'd4:    hdr_byte <= crc[15:8];
               3'd5:    hdr_byte <= crc[7:0];
               default: hdr_byte <= 8'h00;
            endcase
         end
         if (entry_data)
            data_miss <= !tag_hit;
         else if (stb_nxt && state_nxt == ST_DATA && !tag_hit)
            data_miss <= 1'b1;
      end
   end

   floppy_sector_buf #(.DEPTH(1024), .AW(10)) u_buf (
      .clk   (clk),
      .wr    (buf_wr),
      .waddr (buf_addr),
      .wdata (buf_din),
      .raddr (10'(cnt_nxt)),
      .q     (ram_q)
   );

   assign dout_stb = stb_q;
   assign dout_hdr = hdr_q;
   assign dout     = !stb_q ? 8'h00 : hdr_q ? hdr_byte : (data_ok ? ram_q : 8'h00);

`ifdef FLOPPY_STREAM_DCRC_EN
   logic first_q, last_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         data_crc     <= CRC_INIT;
         data_crc_stb <= 1'b0;
      end else begin
         data_crc_stb <= 1'b0;
         if (dclk_en) begin
            first_q <= (cnt_nxt == '0);
            last_q  <= (cnt_nxt == CW'(SECTOR_LEN - 1));
         end
         if (stb_q && !hdr_q) begin
            data_crc     <= crc16_byte(first_q ? CRC_SEED_DATA : data_crc, dout);
            data_crc_stb <= last_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_floppy_stream.sv
// tb/tb_floppy_stream.sv - self-checking bench for floppy_stream
`timescale 1ns/1ps
module tb_floppy_stream;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       dclk_en = 1'b0;
   logic [6:0] track = '0;
   logic [3:0] sector = '0;
   logic       sector_hdr = 1'b0, sector_data = 1'b0, ready = 1'b0, side = 1'b0;
   logic       buf_wr = 1'b0, buf_done = 1'b0;
   logic [9:0] buf_addr = '0;
   logic [7:0] buf_din = '0;
   logic       req, req_side, dout_stb, dout_hdr, data_miss;
   logic [6:0] req_track;
   logic [3:0] req_sector;
   logic [7:0] dout;
`ifdef FLOPPY_STREAM_DCRC_EN
   logic [15:0] data_crc;
   logic        data_crc_stb;
`endif

   floppy_stream dut (
      .clk(clk), .reset_n(reset_n), .dclk_en(dclk_en), .track(track), .sector(sector),
      .sector_hdr(sector_hdr), .sector_data(sector_data), .ready(ready), .side(side),
      .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_din(buf_din), .buf_done(buf_done),
      .req(req), .req_track(req_track), .req_side(req_side), .req_sector(req_sector),
      .dout(dout), .dout_stb(dout_stb), .dout_hdr(dout_hdr), .data_miss(data_miss)
`ifdef FLOPPY_STREAM_DCRC_EN
      , .data_crc(data_crc), .data_crc_stb(data_crc_stb)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       stb;
      logic       hdr;
      logic [7:0] b;
   } sb_t;

   typedef struct {
      logic [6:0] t;
      logic       s;
      logic [3:0] sec;
      logic       bd;
      int         len;
      logic       exp_req;
      logic [6:0] rt;
      logic       rs;
      logic [3:0] rsec;
      logic       miss;
   } vec_t;

   sb_t        sb[$];
   vec_t       vt[6];
   logic [7:0] mem_m [1024];
   int         total = 0;
   int         bad = 0;
   logic       en_d = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_sw(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   always @(posedge clk) en_d <= dclk_en;

   always @(negedge clk) begin
      sb_t e;
      if (reset_n) begin
         if (en_d) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("stb", {31'd0, dout_stb}, {31'd0, e.stb});
               if (e.stb) begin
                  chk("dout", {24'd0, dout}, {24'd0, e.b});
                  chk("dout_hdr", {31'd0, dout_hdr}, {31'd0, e.hdr});
               end
            end
         end else if (dout_stb) begin
            chk("stb_timing", 32'd1, 32'd0);
         end
      end
   end

   task automatic pulse(input logic hdr, input logic dat, input logic rdy, input logic bd,
                        input logic exp_stb, input logic exp_hdr, input logic [7:0] exp_b);
      sb_t e;
      @(negedge clk);
      sector_hdr = hdr; sector_data = dat; ready = rdy; buf_done = bd; dclk_en = 1'b1;
      e.stb = exp_stb; e.hdr = exp_hdr; e.b = exp_b;
      sb.push_back(e);
      @(negedge clk);
      dclk_en = 1'b0; buf_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic hdr_window(input logic [6:0] t, input logic s, input logic [3:0] sec,
                             input logic bd, input int nr);
      logic [7:0]  b [6];
      logic [15:0] c;
      track = t; side = s; sector = sec;
      b[0] = {1'b0, t}; b[1] = {7'd0, s}; b[2] = {4'd0, sec}; b[3] = 8'h03;
      c = 16'hFFFF;
      c = crc_sw(c, 8'hA1); c = crc_sw(c, 8'hA1); c = crc_sw(c, 8'hA1); c = crc_sw(c, 8'hFE);
      for (int k = 0; k < 4; k++) c = crc_sw(c, b[k]);
      b[4] = c[15:8]; b[5] = c[7:0];
      for (int k = 0; k < nr; k++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 8; k++)
         pulse(1'b1, 1'b0, 1'b1, (k == 0) && bd, k < 6, 1'b1, (k < 6) ? b[k] : 8'h00);
      repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic data_window(input int len, input logic hit, input int drop);
      for (int i = 0; i < len; i++)
         pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, hit ? mem_m[i % 1024] : 8'h00);
      for (int i = 0; i < drop; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (len == 1024) repeat (2) pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic chk_req(input string name, input logic r, input logic [6:0] t,
                          input logic s, input logic [3:0] sec);
      chk({name, "_req"}, {31'd0, req}, {31'd0, r});
      chk({name, "_reqtag"}, {20'd0, req_track, req_side, req_sector}, {20'd0, t, s, sec});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{t:7'd0,   s:1'b0, sec:4'd0,  bd:1'b1, len:1024, exp_req:1'b0, rt:7'd0,   rs:1'b0, rsec:4'd0,  miss:1'b0};
      vt[1] = '{t:7'd7,   s:1'b1, sec:4'd9,  bd:1'b0, len:1024, exp_req:1'b1, rt:7'd7,   rs:1'b1, rsec:4'd9,  miss:1'b1};
      vt[2] = '{t:7'd7,   s:1'b1, sec:4'd9,  bd:1'b1, len:1024, exp_req:1'b0, rt:7'd7,   rs:1'b1, rsec:4'd9,  miss:1'b0};
      vt[3] = '{t:7'd7,   s:1'b1, sec:4'd9,  bd:1'b0, len:16,   exp_req:1'b0, rt:7'd7,   rs:1'b1, rsec:4'd9,  miss:1'b0};
      vt[4] = '{t:7'd3,   s:1'b0, sec:4'd4,  bd:1'b0, len:0,    exp_req:1'b1, rt:7'd3,   rs:1'b0, rsec:4'd4,  miss:1'b0};
      vt[5] = '{t:7'd127, s:1'b1, sec:4'd15, bd:1'b0, len:5,    exp_req:1'b1, rt:7'd127, rs:1'b1, rsec:4'd15, miss:1'b1};

      repeat (3) @(negedge clk);
      chk("reset_outputs", {8'd0, req, req_track, req_side, req_sector, dout, dout_stb, dout_hdr, data_miss}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         buf_wr = 1'b1; buf_addr = 10'(i); buf_din = 8'(i);
         mem_m[i] = 8'(i);
      end
      @(negedge clk);
      buf_wr = 1'b0;

      hdr_window(7'd5, 1'b0, 4'd2, 1'b0, 0);
      chk_req("first_hdr", 1'b1, 7'd5, 1'b0, 4'd2);
      @(negedge clk); buf_done = 1'b1;
      @(negedge clk); buf_done = 1'b0;
      chk_req("after_done", 1'b0, 7'd5, 1'b0, 4'd2);
      data_window(1024, 1'b1, 0);
      chk("miss_hit", {31'd0, data_miss}, 32'd0);

      for (int i = 0; i < 300; i++) pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, mem_m[i]);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_mid_data", {8'd0, req, req_track, req_side, req_sector, dout, dout_stb, dout_hdr, data_miss}, 32'd0);
      sector_data = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      hdr_window(7'd5, 1'b0, 4'd2, 1'b0, 0);
      chk_req("tag_invalid_after_reset", 1'b1, 7'd5, 1'b0, 4'd2);

      hdr_window(7'd0, 1'b0, 4'd0, 1'b0, 0);
      chk_req("relatch", 1'b1, 7'd0, 1'b0, 4'd0);

      for (int v = 0; v < 6; v++) begin
         hdr_window(vt[v].t, vt[v].s, vt[v].sec, vt[v].bd, 0);
         chk_req($sformatf("vec%0d", v), vt[v].exp_req, vt[v].rt, vt[v].rs, vt[v].rsec);
         if (vt[v].len > 0) begin
            data_window(vt[v].len, !vt[v].miss, 0);
            chk($sformatf("vec%0d_miss", v), {31'd0, data_miss}, {31'd0, vt[v].miss});
         end
      end

      hdr_window(7'd127, 1'b1, 4'd15, 1'b1, 0);
      chk_req("ready_setup", 1'b0, 7'd127, 1'b1, 4'd15);
      data_window(300, 1'b1, 2);
      hdr_window(7'd127, 1'b1, 4'd15, 1'b0, 2);
      chk_req("ready_hdr", 1'b0, 7'd127, 1'b1, 4'd15);

      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
